branch_resolve_bht: RTL and testbench
=====================================

Name: branch_resolve_bht

Overview:
- Next-generation branch unit for the single-issue NPC core. Evaluates branch conditions from ALU flags and computes the redirect target.
- Adds a parametrised branch history table (BHT) of saturating counters: it predicts direction at fetch and trains at execute.
- Sits between EXU (resolve side) and IFU (predict/redirect side). Also keeps saturating branch/mispredict statistics for difftest/perf dumps.

Parameters:
- XLEN, 32, datapath/PC width.
- BHT_DEPTH, 64, number of counters; power of two, >=2.
- CNT_W, 2, counter width; >=1.
- STAT_W, 32, width of statistics counters.

Ports:
- clk  in  1  clock, all state rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- if_pc  in  XLEN  fetch PC to predict.
- if_pred_taken  out  1  combinational: MSB of BHT[if_pc[IDX+1:2]], IDX=log2(BHT_DEPTH).
- ex_valid  in  1  resolve request valid.
- ex_pc  in  XLEN  PC of resolving instruction.
- ex_branch  in  3  branch type code.
- ex_less  in  1  ALU less flag.
- ex_zero  in  1  ALU zero flag.
- ex_imm  in  XLEN  immediate.
- ex_rs1  in  XLEN  rs1 value.
- ex_pred_taken  in  1  prediction fetch used for this instruction.
- flush  in  1  trap/kill; squashes current ex request.
- redirect_valid  out  1  registered; IFU must refetch.
- redirect_pc  out  XLEN  registered target.
- illegal_br  out  1  registered one-cycle pulse: reserved code seen.
- br_cnt  out  STAT_W  resolved conditional branches.
- miss_cnt  out  STAT_W  mispredicted conditional branches.

Behaviour:
- Branch codes:
  - 000: none.
  - 001: jal, target = ex_pc+ex_imm.
  - 010: jalr, target = (ex_rs1+ex_imm) & ~1.
  - 011: reserved.
  - 100: beq, taken=zero.
  - 101: bne, taken=!zero.
  - 110: blt/bltu, taken=less.
  - 111: bge/bgeu, taken=!less.
- Accept = ex_valid & !flush. Requests with flush=1 have no effect on any state.
- All target arithmetic is modulo 2^XLEN; wrap-around is silent.
- Conditional (1xx), accepted:
  - Mispredict = taken != ex_pred_taken.
  - On mispredict: next cycle redirect_valid=1; redirect_pc = taken ? ex_pc+ex_imm : ex_pc+4.
  - No mispredict: redirect_valid=0.
  - br_cnt += 1; miss_cnt += 1 on mispredict. Both saturate at all-ones.
  - BHT[ex_pc[IDX+1:2]] increments if taken, decrements if not. Saturates at 0 and 2^CNT_W-1.
- jal/jalr, accepted: redirect_valid=1 next cycle with the target above. ex_pred_taken is ignored; no BHT or stat update.
- 000, accepted: no redirect, no update.
- 011, accepted: illegal_br=1 for one cycle, no redirect, no update.
- Latency: redirect/illegal outputs are registered, exactly 1 cycle after the accept edge. They deassert the following cycle unless a new qualifying accept occurs.
- Back-to-back accepts every cycle must be supported; there is no stall.
- Same-cycle BHT read (if_pc) and update at the same index: the read returns the pre-update value. There is no bypass.
- Reset (async, any time, including mid-stream):
  - All BHT counters = 2^(CNT_W-1)-1 (weakly not-taken, 01 for CNT_W=2).
  - redirect_valid=0, redirect_pc=0, illegal_br=0, br_cnt=0, miss_cnt=0.
  - A request pending at reset assertion is lost.
- flush asserted in the cycle after an accept does not cancel the already-registered redirect. Redirect priority is the IFU's concern.

Test Plan:
- Reset, then read if_pc=0x80000000 -> if_pred_taken=0. All outputs 0; every index reads 01.
- beq at ex_pc=0x80000010, ex_zero=1, ex_pred_taken=0, ex_imm=0x20 -> next cycle redirect_valid=1, redirect_pc=0x80000030, br_cnt=1, miss_cnt=1. Counter at index 4 = 10, so if_pc=0x80000010 then predicts 1.
- bge at ex_pc=0x80000040, ex_less=0, ex_pred_taken=1 -> no redirect, br_cnt+1, miss_cnt unchanged. Training taken 5 times leaves the counter at 11 (saturated); one not-taken -> 10, prediction still 1.
- jalr with ex_rs1=0x80001003, ex_imm=4 -> redirect_pc=0x80001006. jal with ex_pc=0xFFFFFFFC, ex_imm=8 -> redirect_pc=0x00000004 (wrap). Neither changes stats.
- ex_branch=011 -> illegal_br pulses exactly 1 cycle, no redirect. Any code presented with flush=1 -> no output, no BHT/stat change.
- Alternate mispredicts every cycle for 10 cycles, with rst_n dropped mid-burst on cycle 6 -> redirect_valid drops immediately and counters clear. After release, preset br_cnt to 0xFFFFFFFF via forced stimulus: one more branch keeps it at 0xFFFFFFFF.

Source files
------------

// File: rtl/branch_resolve_bht.sv
// Branch resolve unit with a saturating-counter branch history table.
// Predicts direction at fetch, trains and redirects at execute, keeps branch/miss stats.
module branch_resolve_bht #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 2,
  parameter int STAT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   if_pc,
  output logic              if_pred_taken,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [2:0]        ex_branch,
  input  logic              ex_less,
  input  logic              ex_zero,
  input  logic [XLEN-1:0]   ex_imm,
  input  logic [XLEN-1:0]   ex_rs1,
  input  logic              ex_pred_taken,
  input  logic              flush,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              illegal_br,
  output logic [STAT_W-1:0] br_cnt,
  output logic [STAT_W-1:0] miss_cnt
);

  localparam int IDX = $clog2(BHT_DEPTH);

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [IDX-1:0]    idx_t;
  typedef logic [STAT_W-1:0] stat_t;

  localparam cnt_t CNT_INIT = cnt_t'((1 << (CNT_W - 1)) - 1);
  localparam cnt_t CNT_MAX  = '1;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_JAL  = 3'b001,
    BR_JALR = 3'b010,
    BR_RSVD = 3'b011,
    BR_BEQ  = 3'b100,
    BR_BNE  = 3'b101,
    BR_BLT  = 3'b110,
    BR_BGE  = 3'b111
  } br_e;

  cnt_t            bht [BHT_DEPTH];
  idx_t            if_idx;
  idx_t            ex_idx;
  br_e             br;
  logic            accept;
  logic            is_cond;
  logic            taken;
  logic            mispredict;
  logic            do_redirect;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] jalr_sum;
  logic            unused_if_pc_bits;

  assign if_idx            = if_pc[IDX+1:2];
  assign ex_idx            = ex_pc[IDX+1:2];
  assign unused_if_pc_bits = ^{if_pc[XLEN-1:IDX+2], if_pc[1:0]};

  // Read sees the pre-update counter even when execute trains the same entry.
  assign if_pred_taken = bht[if_idx][CNT_W-1];

  assign br        = br_e'(ex_branch);
  assign accept    = ex_valid & ~flush;
  assign is_cond   = ex_branch[2];
  assign br_target = ex_pc + ex_imm;
  assign seq_pc    = ex_pc + XLEN'(4);
  assign jalr_sum  = ex_rs1 + ex_imm;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    taken       = 1'b0;
    do_redirect = 1'b0;
    target      = br_target;
    case (br)
      BR_JAL:  do_redirect = 1'b1;
      BR_JALR: begin
        do_redirect = 1'b1;
        target      = {jalr_sum[XLEN-1:1], 1'b0};
      end
      BR_BEQ:  taken = ex_zero;
      BR_BNE:  taken = ~ex_zero;
      BR_BLT:  taken = ex_less;
      BR_BGE:  taken = ~ex_less;
      default: ;
    endcase
    mispredict = is_cond & (taken != ex_pred_taken);
    if (mispredict) begin
      do_redirect = 1'b1;
      target      = taken ? br_target : seq_pc;
    end
  end

  // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      illegal_br     <= 1'b0;
      br_cnt         <= '0;
      miss_cnt       <= '0;
    end else begin
      redirect_valid <= accept & do_redirect;
      illegal_br     <= accept & (br == BR_RSVD);
      if (accept && do_redirect) redirect_pc <= target;
      if (accept && is_cond) begin
        if (br_cnt != '1) br_cnt <= br_cnt + stat_t'(1);
        if (mispredict && (miss_cnt != '1)) miss_cnt <= miss_cnt + stat_t'(1);
      end
    end
  end

  // NOTE: the table is flops, not RAM, because every counter must return to weakly not-taken on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CNT_INIT;
    end else if (accept && is_cond) begin
      if (taken) begin
        if (bht[ex_idx] != CNT_MAX) bht[ex_idx] <= bht[ex_idx] + cnt_t'(1);
      end else begin
        if (bht[ex_idx] != '0) bht[ex_idx] <= bht[ex_idx] - cnt_t'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed self-checking bench for branch_resolve_bht; a narrow-stat second
// instance shares the stimulus to reach statistics saturation quickly.
module tb_branch_resolve_bht;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [2:0]  ex_branch;
  logic        ex_less;
  logic        ex_zero;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1;
  logic        ex_pred_taken;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        illegal_br;
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;

  logic        s_pred_taken;
  logic        s_redirect_valid;
  logic [31:0] s_redirect_pc;
  logic        s_illegal_br;
  logic [3:0]  s_br_cnt;
  logic [3:0]  s_miss_cnt;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  branch_resolve_bht dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_branch(ex_branch), .ex_less(ex_less),
    .ex_zero(ex_zero), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_pred_taken(ex_pred_taken),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .illegal_br(illegal_br), .br_cnt(br_cnt), .miss_cnt(miss_cnt)
  );

  branch_resolve_bht #(.STAT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(s_pred_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_branch(ex_branch), .ex_less(ex_less),
    .ex_zero(ex_zero), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_pred_taken(ex_pred_taken),
    .flush(flush), .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
    .illegal_br(s_illegal_br), .br_cnt(s_br_cnt), .miss_cnt(s_miss_cnt)
  );

  task automatic drive(input logic v, input logic [2:0] code, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] rs1, input logic less,
                       input logic zero, input logic pred);
    ex_valid = v; ex_branch = code; ex_pc = pc; ex_imm = imm; ex_rs1 = rs1;
    ex_less = less; ex_zero = zero; ex_pred_taken = pred;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; if_pc = 32'h8000_0000;
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #3;
    tests++;
    if ({redirect_valid, illegal_br} !== 2'b00 || redirect_pc !== 32'h0) begin
      failed++; $display("FAIL reset_outputs: got v=%0b ill=%0b pc=%h want 0 0 0", redirect_valid, illegal_br, redirect_pc);
    end
    tests++;
    if (br_cnt !== 32'h0 || miss_cnt !== 32'h0 || s_br_cnt !== 4'h0) begin
      failed++; $display("FAIL reset_stats: got br=%0d miss=%0d sbr=%0d want 0", br_cnt, miss_cnt, s_br_cnt);
    end
    for (int i = 0; i < 64; i++) begin
      if_pc = 32'h8000_0000 | (i << 2);
      #1;
      tests++;
      if (if_pred_taken !== 1'b0) begin
        failed++; $display("FAIL reset_pred[%0d]: got %0b want 0", i, if_pred_taken);
      end
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_cond();
    drive(1'b1, 3'b100, 32'h8000_0010, 32'h20, 32'h0, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    if_pc = 32'h8000_0010;
    #1;
    tests++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0030) begin
      failed++; $display("FAIL beq_redirect: got v=%0b pc=%h want 1 80000030", redirect_valid, redirect_pc);
    end
    tests++;
    if (br_cnt !== 32'd1 || miss_cnt !== 32'd1) begin
      failed++; $display("FAIL beq_stats: got br=%0d miss=%0d want 1 1", br_cnt, miss_cnt);
    end
    tests++;
    if (if_pred_taken !== 1'b1) begin
      failed++; $display("FAIL beq_trained_pred: got %0b want 1", if_pred_taken);
    end
    step();
    tests++;
    if (redirect_valid !== 1'b0) begin
      failed++; $display("FAIL redirect_deassert: got %0b want 0", redirect_valid);
    end

    // bge taken, correctly predicted, five times: counter 01 -> 11 saturated
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'b111, 32'h8000_0040, 32'h80, 32'h0, 1'b0, 1'b0, 1'b1);
      step();
      tests++;
      if (redirect_valid !== 1'b0 || br_cnt !== 32'(2 + i) || miss_cnt !== 32'd1) begin
        failed++; $display("FAIL bge_taken[%0d]: got v=%0b br=%0d miss=%0d want 0 %0d 1", i, redirect_valid, br_cnt, miss_cnt, 2 + i);
      end
    end
    if_pc = 32'h8000_0040;
    // one not-taken: 11 -> 10, still predicts taken; fall-through redirect
    drive(1'b1, 3'b111, 32'h8000_0040, 32'h80, 32'h0, 1'b1, 1'b0, 1'b1);
    step();
    tests++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0044 || br_cnt !== 32'd7 || miss_cnt !== 32'd2) begin
      failed++; $display("FAIL bge_nt_miss: got v=%0b pc=%h br=%0d miss=%0d want 1 80000044 7 2", redirect_valid, redirect_pc, br_cnt, miss_cnt);
    end
    tests++;
    if (if_pred_taken !== 1'b1) begin
      failed++; $display("FAIL bht_saturate_hi: got %0b want 1", if_pred_taken);
    end
    step();
    tests++;
    if (if_pred_taken !== 1'b0 || miss_cnt !== 32'd3 || br_cnt !== 32'd8) begin
      failed++; $display("FAIL bht_second_nt: got pred=%0b br=%0d miss=%0d want 0 8 3", if_pred_taken, br_cnt, miss_cnt);
    end

    drive(1'b1, 3'b110, 32'h8000_0100, 32'hFFFF_FFF0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    tests++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_00F0) begin
      failed++; $display("FAIL blt_taken_miss: got v=%0b pc=%h want 1 800000f0", redirect_valid, redirect_pc);
    end
    drive(1'b1, 3'b101, 32'h8000_0200, 32'h40, 32'h0, 1'b0, 1'b1, 1'b1);
    step();
    tests++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0204 || br_cnt !== 32'd10 || miss_cnt !== 32'd5) begin
      failed++; $display("FAIL bne_nt_miss: got v=%0b pc=%h br=%0d miss=%0d want 1 80000204 10 5", redirect_valid, redirect_pc, br_cnt, miss_cnt);
    end
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_jump();
    drive(1'b1, 3'b010, 32'h8000_0500, 32'h4, 32'h8000_1003, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b1, 3'b001, 32'hFFFF_FFFC, 32'h8, 32'h0, 1'b0, 1'b0, 1'b1);
    tests++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_1006) begin
      failed++; $display("FAIL jalr_target: got v=%0b pc=%h want 1 80001006", redirect_valid, redirect_pc);
    end
    step();
    // flush now only kills this cycle's request, not the registered jal redirect
    drive(1'b1, 3'b001, 32'h1000, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    tests++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0004) begin
      failed++; $display("FAIL jal_wrap: got v=%0b pc=%h want 1 00000004", redirect_valid, redirect_pc);
    end
    tests++;
    if (br_cnt !== 32'd10 || miss_cnt !== 32'd5) begin
      failed++; $display("FAIL jump_stats: got br=%0d miss=%0d want 10 5", br_cnt, miss_cnt);
    end
    step();
    flush = 1'b0;
    tests++;
    if (redirect_valid !== 1'b0) begin
      failed++; $display("FAIL flushed_jal: got v=%0b want 0", redirect_valid);
    end
  endtask

  task automatic test_illegal();
    drive(1'b1, 3'b011, 32'h8000_0600, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b1, 3'b000, 32'h8000_0604, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1);
    tests++;
    if (illegal_br !== 1'b1 || redirect_valid !== 1'b0) begin
      failed++; $display("FAIL illegal_pulse: got ill=%0b v=%0b want 1 0", illegal_br, redirect_valid);
    end
    step();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (illegal_br !== 1'b0 || redirect_valid !== 1'b0 || br_cnt !== 32'd10) begin
      failed++; $display("FAIL illegal_clear_none: got ill=%0b v=%0b br=%0d want 0 0 10", illegal_br, redirect_valid, br_cnt);
    end
  endtask

  task automatic test_flush();
    // every conditional code is made not-taken and mispredicted; flushed, none may train
    if_pc = 32'h8000_0010;
    flush = 1'b1;
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 3'(c), 32'h8000_0010, 32'h100, 32'h0, (c == 7), (c == 5), 1'b1);
      step();
      tests++;
      if (redirect_valid !== 1'b0 || illegal_br !== 1'b0 || br_cnt !== 32'd10 || miss_cnt !== 32'd5) begin
        failed++; $display("FAIL flush_code%0d: got v=%0b ill=%0b br=%0d miss=%0d want 0 0 10 5", c, redirect_valid, illegal_br, br_cnt, miss_cnt);
      end
    end
    flush = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    tests++;
    if (if_pred_taken !== 1'b1) begin
      failed++; $display("FAIL flush_bht_kept: got %0b want 1", if_pred_taken);
    end
  endtask

  task automatic drive_burst(input int k);
    if (k % 2 == 0) drive(1'b1, 3'b100, 32'h8000_0300, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0);
    else            drive(1'b1, 3'b100, 32'h8000_0300, 32'h40, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    for (int k = 0; k < 5; k++) begin
      drive_burst(k);
      exp_pc = (k % 2 == 0) ? 32'h8000_0340 : 32'h8000_0304;
      step();
      tests++;
      if (redirect_valid !== 1'b1 || redirect_pc !== exp_pc || br_cnt !== 32'(11 + k) || miss_cnt !== 32'(6 + k)) begin
        failed++; $display("FAIL burst[%0d]: got v=%0b pc=%h br=%0d miss=%0d want 1 %h %0d %0d", k, redirect_valid, redirect_pc, br_cnt, miss_cnt, exp_pc, 11 + k, 6 + k);
      end
    end
    drive_burst(5);
    if_pc = 32'h8000_0010;
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (redirect_valid !== 1'b0 || br_cnt !== 32'h0 || miss_cnt !== 32'h0 || s_br_cnt !== 4'h0) begin
      failed++; $display("FAIL midburst_reset: got v=%0b br=%0d miss=%0d sbr=%0d want 0 0 0 0", redirect_valid, br_cnt, miss_cnt, s_br_cnt);
    end
    tests++;
    if (if_pred_taken !== 1'b0) begin
      failed++; $display("FAIL midburst_reset_bht: got %0b want 0", if_pred_taken);
    end
    step();
    tests++;
    if (redirect_valid !== 1'b0 || br_cnt !== 32'h0) begin
      failed++; $display("FAIL reset_request_lost: got v=%0b br=%0d want 0 0", redirect_valid, br_cnt);
    end
    rst_n = 1'b1;
    // 4 more burst cycles, then keep mispredicting until the 4-bit stats saturate
    for (int k = 6; k < 22; k++) begin
      drive_burst(k);
      exp_pc = (k % 2 == 0) ? 32'h8000_0340 : 32'h8000_0304;
      step();
      tests++;
      if (redirect_valid !== 1'b1 || redirect_pc !== exp_pc || br_cnt !== 32'(k - 5) || miss_cnt !== 32'(k - 5)) begin
        failed++; $display("FAIL post_reset[%0d]: got v=%0b pc=%h br=%0d miss=%0d want 1 %h %0d %0d", k, redirect_valid, redirect_pc, br_cnt, miss_cnt, exp_pc, k - 5, k - 5);
      end
      tests++;
      if (s_br_cnt !== 4'((k - 5 > 15) ? 15 : k - 5) || s_miss_cnt !== 4'((k - 5 > 15) ? 15 : k - 5)) begin
        failed++; $display("FAIL stat_saturate[%0d]: got br=%0d miss=%0d want %0d", k, s_br_cnt, s_miss_cnt, (k - 5 > 15) ? 15 : k - 5);
      end
    end
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    tests++;
    if (redirect_valid !== 1'b0 || s_br_cnt !== 4'hF) begin
      failed++; $display("FAIL burst_end: got v=%0b sbr=%0d want 0 15", redirect_valid, s_br_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_cond();
    test_jump();
    test_illegal();
    test_flush();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
